// File: rtl/dyuv_pkg.sv
// Purpose: shared types and defaults for the delta-YUV line sequencing path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dyuv_pkg;

    localparam int DEF_WORDS_PER_LINE = 384;
    localparam int DEF_OUT_PIXELS     = 382;
    localparam int PIX_W              = 8;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_s;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTART = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

endpackage

// File: rtl/dyuv_line_sequencer_if.sv
// Purpose: byte pixel stream with write/strobe handshake (a beat moves when both are high).
// Latency: n/a (wires only).
// Backpressure: consumer holds strobe low to stall; producer holds write low when empty.
// Ports: write/pixel driven by the master, strobe driven by the slave.
interface dyuv_line_sequencer_if;
    import dyuv_pkg::*;

    logic             write;
    logic [PIX_W-1:0] pixel;
    logic             strobe;

    modport master (output write, output pixel, input strobe);
    modport slave  (input write, input pixel, output strobe);
endinterface

// File: rtl/dyuv_line_sequencer.sv
// Purpose: per-line restart, start-YUV double buffer and word gating for the delta-YUV decoder.
// Latency: line_start at T -> RESTART at T+1 (active YUV valid), dec_reset low and first word from T+2.
// Backpressure: fetch.strobe follows dec.strobe while words are owed; forced low once the line quota is met.
// Ports: clk/reset; line_start, dyuv_enable; start_yuv_wdata/we (register file write);
//        fetch (slave stream in), dec (master stream out), dec_reset, dec_start_yuv;
//        dec_out_write/strobe (decoder output, monitored); line_done, overrun, underrun (status).
module dyuv_line_sequencer
    import dyuv_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int OUT_PIXELS     = DEF_OUT_PIXELS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic                  dyuv_enable,
    input  yuv_s                  start_yuv_wdata,
    input  logic                  start_yuv_we,
    dyuv_line_sequencer_if.slave  fetch,
    dyuv_line_sequencer_if.master dec,
    output logic                  dec_reset,
    output yuv_s                  dec_start_yuv,
    input  logic                  dec_out_write,
    input  logic                  dec_out_strobe,
    output logic                  line_done,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int WCW = $clog2(WORDS_PER_LINE + 1);
    localparam int PCW = $clog2(OUT_PIXELS + 1);
    localparam logic [WCW-1:0] WORDS_INIT = WCW'(WORDS_PER_LINE);
    localparam logic [PCW-1:0] PIX_INIT   = PCW'(OUT_PIXELS);

    seq_state_e     state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
    yuv_s           pending_q, pending_d;
    yuv_s           active_q, active_d;
    logic           dec_reset_q, dec_reset_d;
    logic           line_done_q, line_done_d;
    logic           overrun_q, overrun_d;
    logic           underrun_q, underrun_d;

    logic pass;
    logic word_fire;
    logic pix_fire;
    logic line_complete;

    // Stream is open only in RUN while the line still owes words.
    assign pass         = (state_q == ST_RUN) && (word_cnt_q != '0);
    assign dec.write    = pass & fetch.write;
    assign dec.pixel    = fetch.pixel;
    assign fetch.strobe = pass & dec.strobe;

    assign word_fire     = dec.write & dec.strobe;
    assign pix_fire      = dec_out_write & dec_out_strobe;
    assign line_complete = (state_q == ST_RUN) && (word_cnt_q == '0) && (pix_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        pending_d   = start_yuv_we ? start_yuv_wdata : pending_q;
        active_d    = active_q;
        line_done_d = 1'b0;
        overrun_d   = 1'b0;
        underrun_d  = underrun_q;

        case (state_q)
            ST_IDLE: begin
                // line_start handling below covers the IDLE exit.
            end
            ST_RESTART: begin
                word_cnt_d = WORDS_INIT;
                pix_cnt_d  = PIX_INIT;
                underrun_d = 1'b0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (word_fire) begin
                    word_cnt_d = word_cnt_q - 1'b1;
                end
                if (pix_fire && (pix_cnt_q != '0)) begin
                    pix_cnt_d = pix_cnt_q - 1'b1;
                end
                if (pass && !fetch.write && dec.strobe) begin
                    underrun_d = 1'b1;
                end
                // line_done is registered from the counters' next values so it
                // lands in the cycle after the last decrement; the exit to IDLE
                // follows one cycle later from the registered zeros.
                if (line_complete) begin
                    state_d = ST_IDLE;
                end else if ((word_cnt_d == '0) && (pix_cnt_d == '0)) begin
                    line_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (line_start) begin
            // A write coincident with line_start bypasses straight to active.
            active_d    = start_yuv_we ? start_yuv_wdata : pending_q;
            underrun_d  = 1'b0;
            line_done_d = 1'b0;
            if ((state_q == ST_RESTART) || ((state_q == ST_RUN) && !line_complete)) begin
                overrun_d = 1'b1;
            end
            state_d = dyuv_enable ? ST_RESTART : ST_IDLE;
        end

        dec_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            pending_q   <= '0;
            active_q    <= '0;
            dec_reset_q <= 1'b1;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            dec_reset_q <= dec_reset_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    assign dec_reset     = dec_reset_q;
    assign dec_start_yuv = active_q;
    assign line_done     = line_done_q;
    assign overrun       = overrun_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_dyuv_line_sequencer.sv
// Purpose: randomized scoreboard bench for dyuv_line_sequencer with fetcher/decoder models.
// Latency: n/a.
// Backpressure: decoder strobe and downstream strobe randomized; fetcher stalls on request.
module tb_dyuv_line_sequencer;
    import dyuv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, line_start, dyuv_enable, start_yuv_we;
    logic dec_reset, dec_out_write, dec_out_strobe;
    logic line_done, overrun, underrun;
    yuv_s start_yuv_wdata, dec_start_yuv;

    dyuv_line_sequencer_if fetch ();
    dyuv_line_sequencer_if dec ();

    dyuv_line_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .dyuv_enable     (dyuv_enable),
        .start_yuv_wdata (start_yuv_wdata),
        .start_yuv_we    (start_yuv_we),
        .fetch           (fetch),
        .dec             (dec),
        .dec_reset       (dec_reset),
        .dec_start_yuv   (dec_start_yuv),
        .dec_out_write   (dec_out_write),
        .dec_out_strobe  (dec_out_strobe),
        .line_done       (line_done),
        .overrun         (overrun),
        .underrun        (underrun)
    );

    localparam int WPL = 384;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard
    typedef struct packed {
        yuv_s yuv;
        logic und;
    } done_t;

    logic [7:0] exp_bytes[$];
    done_t      exp_done[$];
    int         exp_ovr    = 0;
    int         done_cnt   = 0;
    int         done_mark  = 0;
    int         line_words = 0;
    bit         in_line    = 1'b0;

    // Reference model of the start-YUV double buffer
    yuv_s m_pending = '0;
    yuv_s m_active  = '0;

    // Fetcher / decoder models
    logic [7:0] fq[$];
    logic [7:0] stage_q[$];
    bit         load_req     = 1'b0;
    int         st_at_stage  = -1;
    int         st_len_stage = 0;
    int         stall_at     = -1;
    int         stall_left   = 0;
    int         popped       = 0;
    int         dec_words    = 0;
    int         emitted      = 0;
    bit         stall        = 1'b0;
    bit         f_fire, d_fire, o_fire, rd;

    initial begin
        fetch.write    = 1'b0;
        fetch.pixel    = 8'h00;
        dec.strobe     = 1'b0;
        dec_out_write  = 1'b0;
        dec_out_strobe = 1'b0;
        forever begin
            @(negedge clk);
            f_fire = fetch.write && fetch.strobe;
            d_fire = dec.write && dec.strobe;
            o_fire = dec_out_write && dec_out_strobe;
            rd     = dec_reset;
            @(posedge clk);
            #2;
            if (f_fire && fq.size() > 0) begin
                void'(fq.pop_front());
                popped++;
            end
            if (rd) begin
                dec_words = 0;
                emitted   = 0;
            end else begin
                if (d_fire) dec_words++;
                if (o_fire) emitted++;
            end
            if (load_req) begin
                fq         = stage_q;
                popped     = 0;
                stall_at   = st_at_stage;
                stall_left = st_len_stage;
                load_req   = 1'b0;
            end
            stall = (popped == stall_at) && (stall_left > 0);
            if (stall) stall_left--;
            fetch.write    = (fq.size() > 0) && !stall;
            fetch.pixel    = (fq.size() > 0) ? fq[0] : 8'h00;
            dec.strobe     = stall ? 1'b1 : ($urandom_range(0, 7) != 0);
            // decoder emits one pixel per word after a 2-word priming delay
            dec_out_write  = (dec_words > 2 + emitted);
            dec_out_strobe = ($urandom_range(0, 4) != 0);
        end
    end

    // Monitor
    done_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (dec_reset === 1'b1) line_words = 0;
            if (dec.write && dec.strobe) begin
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", dec.pixel, $time);
                end else begin
                    chk("fwd_byte", 32'(dec.pixel), 32'(exp_bytes.pop_front()));
                end
                line_words++;
            end
            if (line_done === 1'b1) begin
                done_cnt++;
                in_line = 1'b0;
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_line_done: got pulse expected none at %0t", $time);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_yuv", 32'(dec_start_yuv), 32'(e.yuv));
                    chk("done_underrun", 32'(underrun), 32'(e.und));
                    chk("done_word_count", line_words, WPL);
                    chk("done_fetch_strobe", 32'(fetch.strobe), 0);
                end
            end
            if (overrun === 1'b1) begin
                checks++;
                if (exp_ovr == 0) begin
                    errors++;
                    $display("FAIL unexpected_overrun: got pulse expected none at %0t", $time);
                end else begin
                    exp_ovr--;
                end
            end
        end
    end

    task automatic start_line(input bit en, input bit coinc, input yuv_s v,
                              input int nbytes, input int s_at, input int s_len);
        logic [7:0] b[$];
        bit         was_in_line;
        for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom_range(0, 255)));
        @(posedge clk);
        #1;
        line_start      = 1'b1;
        dyuv_enable     = en;
        start_yuv_we    = coinc;
        start_yuv_wdata = v;
        if (coinc) m_pending = v;
        m_active    = m_pending;
        was_in_line = in_line;
        if (in_line) begin
            exp_ovr++;
            if (exp_done.size() > 0) void'(exp_done.pop_back());
            exp_bytes.delete();
        end
        in_line = en;
        if (en) begin
            for (int i = 0; i < nbytes && i < WPL; i++) exp_bytes.push_back(b[i]);
            exp_done.push_back('{m_active, (s_len > 0)});
            done_mark = done_cnt;
        end
        @(posedge clk);
        #1;
        line_start   = 1'b0;
        dyuv_enable  = 1'b0;
        start_yuv_we = 1'b0;
        stage_q      = b;
        st_at_stage  = s_at;
        st_len_stage = s_len;
        load_req     = 1'b1;
        chk("dec_reset_T1", 32'(dec_reset), 1);
        chk("yuv_T1", 32'(dec_start_yuv), 32'(m_active));
        chk("overrun_T1", 32'(overrun), 32'(was_in_line));
        @(posedge clk);
        #1;
        chk("dec_reset_T2", 32'(dec_reset), 32'(!en));
        chk("underrun_T2", 32'(underrun), 0);
    endtask

    task automatic yuv_write(input yuv_s v);
        @(posedge clk);
        #1;
        start_yuv_we    = 1'b1;
        start_yuv_wdata = v;
        m_pending       = v;
        @(posedge clk);
        #1;
        start_yuv_we = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > done_mark) return;
        end
        checks++;
        errors++;
        $display("FAIL line_done_timeout: got %0d done expected %0d", done_cnt, done_mark + 1);
    endtask

    task automatic wait_popped(input int n);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (popped >= n) return;
        end
        checks++;
        errors++;
        $display("FAIL fetch_timeout: got %0d words expected %0d", popped, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   en, coinc;
        yuv_s v;
        reset           = 1'b1;
        line_start      = 1'b0;
        dyuv_enable     = 1'b0;
        start_yuv_we    = 1'b0;
        start_yuv_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_dec_reset", 32'(dec_reset), 1);
        chk("rst_dec_write", 32'(dec.write), 0);
        chk("rst_fetch_strobe", 32'(fetch.strobe), 0);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_yuv", 32'(dec_start_yuv), 0);

        // Full line with a mid-line register write that must not take effect yet
        start_line(1'b1, 1'b0, '0, WPL + 8, -1, 0);
        wait_popped(50);
        yuv_write(yuv_s'{8'h10, 8'h80, 8'h80});
        @(posedge clk);
        #1;
        chk("yuv_hold_midline", 32'(dec_start_yuv), 32'(m_active));
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        chk("strobe_after_done", 32'(fetch.strobe), 0);
        chk("dec_reset_after_done", 32'(dec_reset), 1);

        // Pending write shows up at the next line start
        start_line(1'b1, 1'b0, '0, WPL + 4, -1, 0);
        wait_done();

        // Write coincident with line_start bypasses into active
        start_line(1'b1, 1'b1, yuv_s'{8'h21, 8'h43, 8'h65}, WPL, -1, 0);
        wait_done();

        // Truncated line: 200 words then a new line_start
        start_line(1'b1, 1'b0, '0, 200, -1, 0);
        wait_popped(200);
        start_line(1'b1, 1'b0, '0, WPL + 2, -1, 0);
        wait_done();

        // Fetcher stall at word 100
        start_line(1'b1, 1'b0, '0, WPL, 100, 10);
        wait_popped(101);
        chk("underrun_after_stall", 32'(underrun), 1);
        wait_done();

        // Disabled line: stays idle, nothing forwarded, underrun cleared
        start_line(1'b0, 1'b0, '0, WPL, -1, 0);
        repeat (30) @(posedge clk);
        #1;
        chk("disabled_words", popped, 0);
        chk("disabled_dec_reset", 32'(dec_reset), 1);

        // Reset in the middle of a line
        start_line(1'b1, 1'b1, yuv_s'{8'h55, 8'h66, 8'h77}, WPL, -1, 0);
        wait_popped(60);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_pending = '0;
        m_active  = '0;
        exp_bytes.delete();
        exp_done.delete();
        in_line   = 1'b0;
        stage_q.delete();
        st_at_stage  = -1;
        st_len_stage = 0;
        load_req     = 1'b1;
        chk("rrun_dec_reset", 32'(dec_reset), 1);
        chk("rrun_dec_write", 32'(dec.write), 0);
        chk("rrun_fetch_strobe", 32'(fetch.strobe), 0);
        chk("rrun_underrun", 32'(underrun), 0);
        chk("rrun_line_done", 32'(line_done), 0);
        chk("rrun_overrun", 32'(overrun), 0);
        chk("rrun_yuv", 32'(dec_start_yuv), 0);

        // Randomized lines
        for (int i = 0; i < 5; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            coinc = $urandom_range(0, 1) != 0;
            v     = yuv_s'($urandom);
            start_line(en, coinc, v, WPL + $urandom_range(0, 16), -1, 0);
            if (en) begin
                if ($urandom_range(0, 1) != 0) begin
                    wait_popped(20);
                    yuv_write(yuv_s'($urandom));
                end
                wait_done();
            end else begin
                repeat (10) @(posedge clk);
            end
        end

        repeat (10) @(posedge clk);
        #1;
        chk("leftover_words", exp_bytes.size(), 0);
        chk("leftover_done", exp_done.size(), 0);
        chk("leftover_overrun", exp_ovr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dyuv_line_sequencer.md
# dyuv_line_sequencer

Per-line controller for the delta-YUV decoder. It sits between the pixel fetcher and `delta_yuv_decoder`, and does four things:
- restarts the decoder at every horizontal line start;
- double-buffers the absolute start YUV, so ICA/DCA writes take effect on line boundaries only;
- gates the fetcher's byte stream to exactly one line's worth of words;
- reports line completion and overrun/underrun status to the video timing logic.

## Interface
Parameters:
- `WORDS_PER_LINE`, 384: source bytes forwarded to the decoder per line.
- `OUT_PIXELS`, 382: decoder output pixels expected per line (input words minus the decoder's 2-word priming latency).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high.
- `line_start`  in  1  one-cycle pulse at the start of the active part of each line.
- `dyuv_enable`  in  1  plane coding method is DYUV; level, sampled only at `line_start`.
- `start_yuv_wdata`  in  `yuv_s`  new absolute start YUV from the ICA/DCA register file.
- `start_yuv_we`  in  1  write strobe for `start_yuv_wdata`.
- `fetch`  pixelstream  consumer side from the fetcher (`write`, `pixel` in; `strobe` out).
- `dec`  pixelstream  producer side to the decoder (`write`, `pixel` out; `strobe` in).
- `dec_reset`  out  1  reset to the decoder.
- `dec_start_yuv`  out  `yuv_s`  drives the decoder `absolute_start_yuv`.
- `dec_out_write`  in  1  decoder `write`, monitored.
- `dec_out_strobe`  in  1  downstream `strobe` on the decoder output, monitored.
- `line_done`  out  1  one-cycle pulse when the line has completed.
- `overrun`  out  1  one-cycle pulse: `line_start` arrived before the previous line completed.
- `underrun`  out  1  sticky; fetcher had no data while words were still owed. Cleared at `line_start`.

## Operation
Start-YUV registers:
- `pending`: loaded on every `start_yuv_we`.
- `active`: drives `dec_start_yuv`; loaded from `pending` at `line_start`.
- If `start_yuv_we` and `line_start` occur in the same cycle, the new write data goes directly into both `active` and `pending` (bypass).

States:
- **IDLE**: `dec_reset`=1; fetch and decoder gated off. On `line_start` with `dyuv_enable` → RESTART. On `line_start` without `dyuv_enable` → stay.
- **RESTART** (exactly 1 cycle):
  - `dec_reset`=1.
  - `word_cnt` ← `WORDS_PER_LINE`; `pix_cnt` ← `OUT_PIXELS`.
  - `underrun` cleared.
  - → RUN.
- **RUN**:
  - Pass-through while `word_cnt`≠0: `dec.write` = `fetch.write`, `dec.pixel` = `fetch.pixel`, `fetch.strobe` = `dec.strobe`.
  - `word_cnt` decrements on each cycle with `dec.write && dec.strobe`.
  - When `word_cnt`=0: `dec.write`=0 and `fetch.strobe`=0.
  - `pix_cnt` decrements on each cycle with `dec_out_write && dec_out_strobe`, saturating at 0.
  - When `word_cnt`=0 and `pix_cnt`=0: pulse `line_done` → IDLE.
- **Line start during RUN or RESTART**:
  - Pulse `overrun`.
  - Reload `active` as above.
  - If `dyuv_enable`: → RESTART. Otherwise → IDLE.
- **Underrun detection**: in RUN, `fetch.write`=0 while `word_cnt`≠0 and `dec.strobe`=1 sets `underrun`. The decoder is never blocked by this; the line simply waits.

Counter widths: `word_cnt` and `pix_cnt` are sized `$clog2(param+1)`. Neither counter ever wraps.

## Timing
- Reset values: state IDLE, `dec_reset`=1, `dec.write`=0, `fetch.strobe`=0, `line_done`=0, `overrun`=0, `underrun`=0, `active`=`pending`=0. Reset takes priority over every other event in the same cycle.
- Latency from `line_start` in cycle T:
  - RESTART in T+1, with `active` already valid.
  - `dec_reset` low from T+2.
  - First forwarded word possible in T+2.
- `dec_reset`, `line_done` and `overrun` are registered. `dec.write`/`fetch.strobe` gating is combinational from state and `word_cnt`.
- Last accepted word at cycle W gives `word_cnt`=0 at W+1. `fetch.strobe` is never high with `word_cnt`=0.
- `line_done` is asserted in the cycle after the final `pix_cnt` decrement; IDLE follows one cycle later.
- A `line_start` in the same cycle as the final decrement counts as `overrun`, with no `line_done` for the truncated line.

## Structure
- `yuv_s` and `pixelstream` are reused from the existing `videotypes.svh` and `bus.svh`.
- The state enum and the default constants 384/382 go into the shared video package `dyuv_pkg`.
- No sub-module: a single FSM plus two down-counters plus the YUV double buffer.

## Test plan
- Reset, then `line_start` with `dyuv_enable`=1 and an always-ready fetcher → `dec_reset` low from T+2; exactly 384 words forwarded; after 382 output pixels, `line_done` pulses once and `fetch.strobe` stays 0.
- `start_yuv_we` writes {y=0x10,u=0x80,v=0x80} mid-line → `dec_start_yuv` unchanged until the next `line_start`, then shows 0x10/0x80/0x80 at T+1. A write coincident with `line_start` → new value at T+1.
- `line_start` after 200 words → `overrun` pulse, decoder reset, `word_cnt` reloaded to 384, no `line_done`.
- Fetcher stalls 10 cycles at word 100 → `underrun` set, all 384 words still delivered, `underrun` cleared at the next `line_start`.
- `dyuv_enable`=0 at `line_start` → remain in IDLE, `dec_reset`=1, zero words forwarded.
- `reset` asserted during RUN → next cycle IDLE, all outputs at their reset values, `active`=0.
